// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) widths, bit-position map and combinational encode/syndrome helpers.
package hamming_pkg;

  localparam int unsigned CODE_W = 7;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned PAR_W  = 3;
  localparam int unsigned POS_W  = 3;

  localparam int unsigned P1 = 1;
  localparam int unsigned P2 = 2;
  localparam int unsigned D1 = 3;
  localparam int unsigned P4 = 4;
  localparam int unsigned D2 = 5;
  localparam int unsigned D3 = 6;
  localparam int unsigned D4 = 7;

  typedef logic [CODE_W:1]  code_t;
  typedef logic [DATA_W:1]  data_t;
  typedef logic [PAR_W:1]   par_t;
  typedef logic [POS_W-1:0] pos_t;

  // Received word plus the parity sense it was encoded with.
  typedef struct packed {
    code_t r;
    logic  pt;
  } chan_word_t;

  function automatic code_t encode(input data_t d, input logic pt);
    code_t c;
    c     = '0;
    c[D1] = d[1];
    c[D2] = d[2];
    c[D3] = d[3];
    c[D4] = d[4];
    c[P1] = d[1] ^ d[2] ^ d[4] ^ pt;
    c[P2] = d[1] ^ d[3] ^ d[4] ^ pt;
    c[P4] = d[2] ^ d[3] ^ d[4] ^ pt;
    return c;
  endfunction

  function automatic pos_t syndrome(input code_t r, input logic pt);
    pos_t s;
    s[0] = r[1] ^ r[3] ^ r[5] ^ r[7] ^ pt;
    s[1] = r[2] ^ r[3] ^ r[6] ^ r[7] ^ pt;
    s[2] = r[4] ^ r[5] ^ r[6] ^ r[7] ^ pt;
    return s;
  endfunction

  // One-hot mask selecting code bit `pos`; position 0 selects nothing.
  function automatic code_t pos_mask(input pos_t pos);
    code_t m;
    m = '0;
    if (pos != '0) m = code_t'(1) << POS_W'(pos - POS_W'(1));
    return m;
  endfunction

endpackage

// File: rtl/hamming_codec_decoder.sv
// Stage 2: syndrome, single-bit correction and data extraction, all registered.
module hamming_decoder
  import hamming_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  chan_word_t chan,
  output data_t      data_out,
  output code_t      corrected_code,
  output logic       error_d,
  output pos_t       error_pos,
  output logic       dec_valid
);

  pos_t  syn_c;
  code_t corr_c;

  always_comb begin
    syn_c  = syndrome(chan.r, chan.pt);
    corr_c = chan.r ^ pos_mask(syn_c);
  end

  // Data registers hold when no word arrives; only the valid flag tracks in_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out       <= '0;
      corrected_code <= '0;
      error_d        <= 1'b0;
      error_pos      <= '0;
      dec_valid      <= 1'b0;
    end else begin
      dec_valid <= in_valid;
      if (in_valid) begin
        data_out       <= {corr_c[D4], corr_c[D3], corr_c[D2], corr_c[D1]};
        corrected_code <= corr_c;
        error_d        <= (syn_c != '0);
        error_pos      <= syn_c;
      end
    end
  end

endmodule

// File: rtl/hamming_codec_top.sv
// Encode -> single-bit error injection -> decode loop; encoder and channel in stage 1.
module hamming_codec_top
  import hamming_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [4:1] data_in,
  input  logic       parity_type,
  input  logic       err_inj_en,
  input  logic [2:0] err_inj_pos,
  output logic [7:1] code_out,
  output logic [3:1] parity_out,
  output logic       enc_valid,
  output logic [4:1] data_out,
  output logic [7:1] corrected_code,
  output logic       error_d,
  output logic [2:0] error_pos,
  output logic       dec_valid
);

  code_t      code_c;
  code_t      rx_c;
  chan_word_t chan_q;

  always_comb begin
    code_c = encode(data_in, parity_type);
    rx_c   = err_inj_en ? (code_c ^ pos_mask(err_inj_pos)) : code_c;
  end

  // Stage 1: encoder outputs plus the channel word and its parity sense.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_out   <= '0;
      parity_out <= '0;
      enc_valid  <= 1'b0;
      chan_q     <= '0;
    end else begin
      enc_valid <= in_valid;
      if (in_valid) begin
        code_out   <= code_c;
        parity_out <= {code_c[P4], code_c[P2], code_c[P1]};
        chan_q     <= '{r: rx_c, pt: parity_type};
      end
    end
  end

  hamming_decoder u_dec (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (enc_valid),
    .chan           (chan_q),
    .data_out       (data_out),
    .corrected_code (corrected_code),
    .error_d        (error_d),
    .error_pos      (error_pos),
    .dec_valid      (dec_valid)
  );

endmodule

// File: tb/tb_hamming_codec_top.sv
// Scoreboard bench for hamming_codec_top: driver queues expectations, monitor checks outputs.
module tb_hamming_codec_top;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [4:1] data_in;
  logic       parity_type;
  logic       err_inj_en;
  logic [2:0] err_inj_pos;
  logic [7:1] code_out;
  logic [3:1] parity_out;
  logic       enc_valid;
  logic [4:1] data_out;
  logic [7:1] corrected_code;
  logic       error_d;
  logic [2:0] error_pos;
  logic       dec_valid;

  typedef struct {
    logic [7:1] code;
    logic [3:1] par;
    logic [4:1] data;
    logic [7:1] corr;
    logic       err;
    logic [2:0] pos;
  } exp_t;

  exp_t enc_q[$];
  exp_t dec_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:1] last_code;

  always #5 clk = ~clk;

  hamming_codec_top dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .data_in        (data_in),
    .parity_type    (parity_type),
    .err_inj_en     (err_inj_en),
    .err_inj_pos    (err_inj_pos),
    .code_out       (code_out),
    .parity_out     (parity_out),
    .enc_valid      (enc_valid),
    .data_out       (data_out),
    .corrected_code (corrected_code),
    .error_d        (error_d),
    .error_pos      (error_pos),
    .dec_valid      (dec_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: generic Hamming rule -- parity bit p covers every position j with (j & p) != 0.
  function automatic exp_t model(input logic [4:1] d, input logic pt, input logic en,
                                 input logic [2:0] pos);
    exp_t e;
    logic c[8];
    int   dpos[4] = '{3, 5, 6, 7};
    int   ppos[3] = '{1, 2, 4};
    foreach (c[j]) c[j] = 1'b0;
    for (int k = 0; k < 4; k++) c[dpos[k]] = d[k+1];
    for (int i = 0; i < 3; i++) begin
      c[ppos[i]] = pt;
      for (int j = 1; j <= 7; j++)
        if ((j & ppos[i]) != 0 && j != ppos[i]) c[ppos[i]] = c[ppos[i]] ^ c[j];
    end
    for (int j = 1; j <= 7; j++) e.code[j] = c[j];
    e.par  = {c[4], c[2], c[1]};
    e.data = d;
    e.corr = e.code;
    e.err  = en && (pos != 3'd0);
    e.pos  = e.err ? pos : 3'd0;
    return e;
  endfunction

  task automatic drive(input logic [4:1] d, input logic pt, input logic en,
                       input logic [2:0] pos, input exp_t e);
    @(negedge clk);
    data_in     = d;
    parity_type = pt;
    err_inj_en  = en;
    err_inj_pos = pos;
    in_valid    = 1'b1;
    enc_q.push_back(e);
    dec_q.push_back(e);
    last_code = e.code;
  endtask

  task automatic send(input logic [4:1] d, input logic pt, input logic en, input logic [2:0] pos);
    drive(d, pt, en, pos, model(d, pt, en, pos));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid    = 1'b0;
      data_in     = 4'($urandom);
      parity_type = 1'($urandom);
      err_inj_en  = 1'($urandom);
      err_inj_pos = 3'($urandom);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_code"}, 32'(code_out), 0);
    check({tag, "_par"},  32'(parity_out), 0);
    check({tag, "_encv"}, 32'(enc_valid), 0);
    check({tag, "_data"}, 32'(data_out), 0);
    check({tag, "_corr"}, 32'(corrected_code), 0);
    check({tag, "_errd"}, 32'(error_d), 0);
    check({tag, "_epos"}, 32'(error_pos), 0);
    check({tag, "_decv"}, 32'(dec_valid), 0);
  endtask

  // Monitor: pops the oldest expectation whenever a stage presents a valid word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (enc_valid) begin
          if (enc_q.size() == 0) check("enc_unexpected", 1, 0);
          else begin
            e = enc_q.pop_front();
            check("code_out", 32'(code_out), 32'(e.code));
            check("parity_out", 32'(parity_out), 32'(e.par));
          end
        end
        if (dec_valid) begin
          if (dec_q.size() == 0) check("dec_unexpected", 1, 0);
          else begin
            e = dec_q.pop_front();
            check("data_out", 32'(data_out), 32'(e.data));
            check("corrected_code", 32'(corrected_code), 32'(e.corr));
            check("error_d", 32'(error_d), 32'(e.err));
            check("error_pos", 32'(error_pos), 32'(e.pos));
          end
        end
      end
    end
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    in_valid = 1'b0;
    data_in = '0;
    parity_type = 1'b0;
    err_inj_en = 1'b0;
    err_inj_pos = '0;
    last_code = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Directed vectors with hand-derived expectations.
    e = '{code: 7'b0101101, par: 3'b101, data: 4'b0101, corr: 7'b0101101, err: 1'b0, pos: 3'd0};
    drive(4'b0101, 1'b0, 1'b0, 3'd0, e);
    e = '{code: 7'b1100110, par: 3'b010, data: 4'b1101, corr: 7'b1100110, err: 1'b0, pos: 3'd0};
    drive(4'b1101, 1'b0, 1'b0, 3'd0, e);
    e = '{code: 7'b0000111, par: 3'b011, data: 4'b0001, corr: 7'b0000111, err: 1'b0, pos: 3'd0};
    drive(4'b0001, 1'b0, 1'b0, 3'd0, e);
    e = '{code: 7'b0001011, par: 3'b111, data: 4'b0000, corr: 7'b0001011, err: 1'b0, pos: 3'd0};
    drive(4'b0000, 1'b1, 1'b0, 3'd0, e);
    e = '{code: 7'b0101101, par: 3'b101, data: 4'b0101, corr: 7'b0101101, err: 1'b1, pos: 3'd5};
    drive(4'b0101, 1'b0, 1'b1, 3'd5, e);
    e = '{code: 7'b0001011, par: 3'b111, data: 4'b0000, corr: 7'b0001011, err: 1'b0, pos: 3'd0};
    drive(4'b0000, 1'b1, 1'b1, 3'd0, e);
    idle(3);
    check("hold_code_out", 32'(code_out), 32'(last_code));
    check("hold_enc_valid", 32'(enc_valid), 0);

    // Exhaustive single-error sweep, back-to-back.
    for (int pt = 0; pt < 2; pt++)
      for (int d = 0; d < 16; d++)
        for (int p = 1; p <= 7; p++)
          send(4'(d), 1'(pt), 1'b1, 3'(p));
    idle(2);

    // Random traffic with alternating parity and random gaps.
    for (int i = 0; i < 200; i++) begin
      send(4'($urandom), 1'(i % 2), 1'($urandom), 3'($urandom));
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    // Reset mid-stream, away from a clock edge.
    for (int i = 0; i < 4; i++) send(4'($urandom), 1'(i % 2), 1'($urandom), 3'($urandom));
    @(posedge clk);
    #3 rst = 1'b1;
    in_valid = 1'b0;
    #1 check_all_zero("midrst");
    enc_q.delete();
    dec_q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    idle(3);
    check("post_rst_encv", 32'(enc_valid), 0);
    check("post_rst_decv", 32'(dec_valid), 0);
    send(4'b1010, 1'b1, 1'b1, 3'd3);
    idle(1);
    check("lat1_encv", 32'(enc_valid), 1);
    check("lat1_decv", 32'(dec_valid), 0);
    @(negedge clk);
    check("lat2_decv", 32'(dec_valid), 1);

    for (int i = 0; i < 20 && (enc_q.size() != 0 || dec_q.size() != 0); i++) idle(1);
    check("drain_enc_q", 32'(enc_q.size()), 0);
    check("drain_dec_q", 32'(dec_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_codec_top.md
# hamming_codec_top

Single-clock Hamming(7,4) codec wrapper: encodes a 4-bit data word into a 7-bit code word with selectable even/odd parity, passes it through an optional single-bit error-injection point, then decodes, locates and corrects any single-bit error. It sits as a self-contained encode → channel → decode loop, used for ECC bring-up and as the reference datapath for downstream ECC blocks.

## Interface
- No parameters; widths are fixed at 4 data bits and 7 code bits.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  data_in/parity_type/injection inputs are valid this cycle
- data_in  in  4 [4:1]  data word; bit k is data bit dk
- parity_type  in  1  0 = even parity, 1 = odd parity
- err_inj_en  in  1  flip one code bit between encoder and decoder
- err_inj_pos  in  3  bit position 1..7 to flip; 0 = no flip even if enabled
- code_out  out  7 [7:1]  encoded word before injection
- parity_out  out  3 [3:1]  {p4,p2,p1} of the encoded word
- enc_valid  out  1  code_out/parity_out valid
- data_out  out  4 [4:1]  corrected data word
- corrected_code  out  7 [7:1]  corrected code word
- error_d  out  1  nonzero syndrome detected
- error_pos  out  3  syndrome = erroneous bit position (0 = none)
- dec_valid  out  1  decoder outputs valid

## Operation
- Code layout [7:1] = {d4,d3,d2,p4,d1,p2,p1}.
- p1 = d1^d2^d4^parity_type; p2 = d1^d3^d4^parity_type; p4 = d2^d3^d4^parity_type.
- Received word r = code_out with bit err_inj_pos inverted when err_inj_en=1 and err_inj_pos≠0; otherwise r = code_out.
- Syndrome s1 = r1^r3^r5^r7^pt, s2 = r2^r3^r6^r7^pt, s4 = r4^r5^r6^r7^pt, where pt is the parity_type that travelled with the word; error_pos = {s4,s2,s1}.
- error_d = (error_pos ≠ 0). corrected_code = r with bit error_pos inverted when nonzero, else r. data_out = {c7,c6,c5,c3} of corrected_code.
- Exactly one bit error is always corrected; double errors are miscorrected (no SECDED), by design.
- parity_type and injection controls are pipelined with their data word; mid-stream parity_type changes never affect words already in flight.

## Timing
- Stage 1 (posedge after in_valid): code_out, parity_out, enc_valid=1, plus registered r and pt.
- Stage 2 (next posedge): data_out, corrected_code, error_d, error_pos, dec_valid=1.
- Latency: encoder outputs 1 cycle, decoder outputs 2 cycles after in_valid. Throughput one word per cycle, no backpressure.
- in_valid=0: valid flags drop in the corresponding stage; data registers hold their previous values.
- Reset (asynchronous, any time): all outputs and pipeline registers go to 0 immediately, including enc_valid/dec_valid; words in flight are discarded. First valid output follows the normal latency after rst deasserts.

## Structure
- Shared package hamming_pkg: code width 7, data width 4, position constants (P1=1, P2=2, D1=3, P4=4, D2=5, D3=6, D4=7), combinational encode and syndrome functions.
- One natural sub-module: hamming_decoder (syndrome, correction, data extraction, stage-2 registers); encoder and injection stay in the top.

## Test plan
- Even, data_in=0101, no injection → code_out=0101101, parity_out=101 at +1; data_out=0101, error_d=0, error_pos=000 at +2.
- Even, data_in=1101 → code_out=1100110, parity_out=010; 0001 → 0000111, parity_out=011; data_out equals data_in, error_d=0.
- Odd, data_in=0000 → code_out=0001011, parity_out=111; decoder error_d=0, data_out=0000.
- Even, 0101, err_inj_en=1, err_inj_pos=5 → error_d=1, error_pos=101, corrected_code=0101101, data_out=0101; sweep all positions 1..7 for all 16 data words and both parity types, each must correct.
- Back-to-back words every cycle with alternating parity_type → each output pair matches its own input; then assert rst mid-stream → all outputs 0 immediately, valids low until two cycles after next in_valid.
